// File: rtl/ibm1620_core_pkg.sv
// Shared constants, state encoding and parity helper for the IBM 1620 core
// memory cycle model.
package ibm1620_core_pkg;

   localparam int DEPTH_DEFAULT = 20000;
   localparam int DIGIT_W       = 6;

   // Bit positions inside a digit {C,F,8,4,2,1}
   localparam int BIT_C = 5;
   localparam int BIT_F = 4;
   localparam int BIT_8 = 3;
   localparam int BIT_4 = 2;
   localparam int BIT_2 = 1;
   localparam int BIT_1 = 0;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_READ   = 3'd1,
      ST_STROBE = 3'd2,
      ST_WRITE  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   // A valid digit carries an odd number of ones; anything else is an error.
   function automatic logic parity_err(input logic [DIGIT_W-1:0] digit);
      return ~(^digit);
   endfunction

endpackage

// File: rtl/ibm1620_core_plane.sv
// DEPTH x 6 ferrite plane: destructive read-clear port and a write port that
// sets every bit whose inhibit line is low.  Core contents survive reset.
module ibm1620_core_plane
   import ibm1620_core_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ADDR_W = 15
) (
   input  logic                clk,
   input  logic                rd_clr_en_i,
   input  logic [ADDR_W-1:0]   rd_addr_i,
   output logic [DIGIT_W-1:0]  rd_data_o,
   input  logic                wr_en_i,
   input  logic [ADDR_W-1:0]   wr_addr_i,
   input  logic [DIGIT_W-1:0]  inhibit_i
);

   logic [DIGIT_W-1:0] mem_q [DEPTH];
   logic [DIGIT_W-1:0] rd_data_q;

   // Sensing a location flips every core to zero; writing restores uninhibited bits.
   always_ff @(posedge clk) begin
      if (rd_clr_en_i) begin
         rd_data_q          <= mem_q[rd_addr_i];
         mem_q[rd_addr_i]   <= 6'b000000;
      end
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= ~inhibit_i;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ibm1620_core_cycle.sv
// One IBM 1620 core memory cycle: read (destructive), strobe, write/regenerate,
// done.  Out-of-range addresses complete immediately with an address error.
module ibm1620_core_cycle
   import ibm1620_core_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEFAULT,
   parameter int ADDR_W = 15
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DIGIT_W-1:0]  req_data,
   output logic                rsp_valid,
   output logic [DIGIT_W-1:0]  rsp_data,
   output logic                rsp_parity_err,
   output logic                rsp_addr_err,
   output logic                rd_drive,
   output logic                wr_drive,
   output logic [DIGIT_W-1:0]  inhibit
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    mar_q, mar_d;
   logic [DIGIT_W-1:0]   mbr_q, mbr_d;
   logic                 write_q, write_d;
   logic [DIGIT_W-1:0]   wdata_q, wdata_d;
   logic                 ready_q, ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic [DIGIT_W-1:0]   rsp_data_q, rsp_data_d;
   logic                 perr_q, perr_d;
   logic                 aerr_q, aerr_d;
   logic                 rd_drive_q, rd_drive_d;
   logic                 wr_drive_q, wr_drive_d;
   logic [DIGIT_W-1:0]   inhibit_q, inhibit_d;
   logic [DIGIT_W-1:0]   sensed_s;
   logic                 accept_s;

   assign accept_s = req_valid & ready_q;

   ibm1620_core_plane #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_plane (
      .clk         (clk),
      .rd_clr_en_i (state_q == ST_READ),
      .rd_addr_i   (mar_q),
      .rd_data_o   (sensed_s),
      .wr_en_i     (state_q == ST_WRITE),
      .wr_addr_i   (mar_q),
      .inhibit_i   (inhibit_q)
   );

   // Next-state and output decode; drives are registered so they align with their state.
   always_comb begin
      state_d     = state_q;
      mar_d       = mar_q;
      mbr_d       = mbr_q;
      write_d     = write_q;
      wdata_d     = wdata_q;
      rsp_data_d  = rsp_data_q;
      perr_d      = perr_q;
      aerr_d      = aerr_q;
      rsp_valid_d = 1'b0;
      rd_drive_d  = 1'b0;
      wr_drive_d  = 1'b0;
      inhibit_d   = 6'b000000;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               mar_d   = req_addr;
               write_d = req_write;
               wdata_d = req_data;
               if (req_addr > LAST_ADDR) begin
                  state_d     = ST_DONE;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = 6'b000000;
                  perr_d      = 1'b0;
                  aerr_d      = 1'b1;
               end else begin
                  state_d    = ST_READ;
                  rd_drive_d = 1'b1;
                  aerr_d     = 1'b0;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            state_d = ST_STROBE;
         end
         ST_STROBE: begin
            state_d    = ST_WRITE;
            rsp_data_d = sensed_s;
            perr_d     = parity_err(sensed_s);
            if (write_q) begin
               mbr_d = wdata_q;
            end else begin
               mbr_d = sensed_s;
            end
            wr_drive_d = 1'b1;
            inhibit_d  = ~mbr_d;
         end
         ST_WRITE: begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   // State register; a reset mid-cycle abandons the digit already cleared by the read.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mar_q       <= '0;
         mbr_q       <= 6'b000000;
         write_q     <= 1'b0;
         wdata_q     <= 6'b000000;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 6'b000000;
         perr_q      <= 1'b0;
         aerr_q      <= 1'b0;
         rd_drive_q  <= 1'b0;
         wr_drive_q  <= 1'b0;
         inhibit_q   <= 6'b000000;
      end else begin
         state_q     <= state_d;
         mar_q       <= mar_d;
         mbr_q       <= mbr_d;
         write_q     <= write_d;
         wdata_q     <= wdata_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         perr_q      <= perr_d;
         aerr_q      <= aerr_d;
         rd_drive_q  <= rd_drive_d;
         wr_drive_q  <= wr_drive_d;
         inhibit_q   <= inhibit_d;
      end
   end

   assign req_ready      = ready_q;
   assign rsp_valid      = rsp_valid_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_parity_err = perr_q;
   assign rsp_addr_err   = aerr_q;
   assign rd_drive       = rd_drive_q;
   assign wr_drive       = wr_drive_q;
   assign inhibit        = inhibit_q;

endmodule

// File: tb/tb_ibm1620_core_cycle.sv
// Scoreboard bench for ibm1620_core_cycle: stimulus pushes expected responses,
// a negedge monitor checks phases, inhibit, latency and response contents.
module tb_ibm1620_core_cycle;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [14:0] req_addr = 15'd0;
   logic [5:0]  req_data = 6'b000000;
   logic        req_ready, rsp_valid, rsp_parity_err, rsp_addr_err, rd_drive, wr_drive;
   logic [5:0]  rsp_data, inhibit;

   ibm1620_core_cycle dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_data       (req_data),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .rsp_parity_err (rsp_parity_err),
      .rsp_addr_err   (rsp_addr_err),
      .rd_drive       (rd_drive),
      .wr_drive       (wr_drive),
      .inhibit        (inhibit)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] rdata;
      logic       perr;
      logic       aerr;
      int         lat;
      bit         chk;
      bit         inh_chk;
      logic [5:0] inh;
   } exp_t;

   exp_t       sbq[$];
   logic [5:0] model [int];
   int         n_chk = 0;
   int         n_fail = 0;
   int         cycle_cnt = 0;
   int         cyc = 0;
   bit         acc_flag = 1'b0;
   bit         busy = 1'b0;
   logic [5:0] last_data = 6'b000000;
   logic       last_perr = 1'b0;
   logic       last_aerr = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   always @(posedge clk) cycle_cnt++;

   // Monitor: cyc counts cycles since the accept edge (READ = 1 ... DONE = 4).
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         acc_flag  = 1'b0;
         busy      = 1'b0;
         cyc       = 0;
         last_data = 6'b000000;
         last_perr = 1'b0;
         last_aerr = 1'b0;
      end else begin
         if (acc_flag) begin
            cyc  = 1;
            busy = 1'b1;
         end else begin
            cyc++;
         end
         chk("req_ready", {31'd0, req_ready}, {31'd0, !busy});
         if (!busy) begin
            chk("hold_rsp_data", {26'd0, rsp_data}, {26'd0, last_data});
            chk("hold_perr", {31'd0, rsp_parity_err}, {31'd0, last_perr});
            chk("hold_aerr", {31'd0, rsp_addr_err}, {31'd0, last_aerr});
         end
         if (rd_drive) begin
            chk("rd_drive_cycle", cyc, 1);
            if (sbq.size() == 0) chk("rd_drive_unexpected", {31'd0, rd_drive}, 32'd0);
            else chk("rd_drive_on_addr_err", {31'd0, sbq[0].aerr}, 32'd0);
         end
         if (wr_drive) begin
            chk("wr_drive_cycle", cyc, 3);
            if (sbq.size() > 0 && sbq[0].inh_chk) chk("inhibit", {26'd0, inhibit}, {26'd0, sbq[0].inh});
         end else begin
            chk("inhibit_idle", {26'd0, inhibit}, 32'd0);
         end
         if (rsp_valid) begin
            if (sbq.size() == 0) begin
               chk("unexpected_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("rsp_latency", cyc, e.lat);
               chk("rsp_addr_err", {31'd0, rsp_addr_err}, {31'd0, e.aerr});
               if (e.chk) begin
                  chk("rsp_data", {26'd0, rsp_data}, {26'd0, e.rdata});
                  chk("rsp_parity_err", {31'd0, rsp_parity_err}, {31'd0, e.perr});
               end
            end
            busy      = 1'b0;
            last_data = rsp_data;
            last_perr = rsp_parity_err;
            last_aerr = rsp_addr_err;
         end
         acc_flag = req_valid && req_ready;
      end
   end

   task automatic issue(input bit wr, input int addr, input logic [5:0] d, input bit keep,
                        output int acc_at);
      exp_t       e;
      logic [5:0] pre, mbr;
      bit         known, got;
      if (addr >= 20000) begin
         e.rdata = 6'b000000; e.perr = 1'b0; e.aerr = 1'b1; e.lat = 1;
         e.chk = 1'b1; e.inh_chk = 1'b0; e.inh = 6'b000000;
      end else begin
         known   = model.exists(addr);
         pre     = known ? model[addr] : 6'b000000;
         mbr     = wr ? d : pre;
         e.rdata = pre; e.perr = ~(^pre); e.aerr = 1'b0; e.lat = 4;
         e.chk = known; e.inh_chk = wr || known; e.inh = ~mbr;
         if (wr) model[addr] = d;
      end
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr[14:0];
      req_data  = d;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = req_ready;
      end
      chk("accept_timeout", {31'd0, got}, 32'd1);
      sbq.push_back(e);
      acc_at = cycle_cnt;
      @(posedge clk);
      #1;
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 40 && sbq.size() != 0; i++) @(negedge clk);
      chk("drain", sbq.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, a1, a2;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_ready", {31'd0, req_ready}, 32'd1);
      chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("reset_rsp_data", {26'd0, rsp_data}, 32'd0);
      chk("reset_perr", {31'd0, rsp_parity_err}, 32'd0);
      chk("reset_aerr", {31'd0, rsp_addr_err}, 32'd0);
      chk("reset_drives", {30'd0, rd_drive, wr_drive}, 32'd0);
      chk("reset_inhibit", {26'd0, inhibit}, 32'd0);
      @(posedge clk); #1;

      issue(1'b1, 100, 6'b000001, 1'b0, a0); wait_idle();
      issue(1'b0, 100, 6'b000000, 1'b0, a0); wait_idle();
      issue(1'b0, 100, 6'b111111, 1'b0, a0); wait_idle();
      issue(1'b1, 5, 6'b000011, 1'b0, a0);   wait_idle();
      issue(1'b0, 5, 6'b000000, 1'b0, a0);   wait_idle();
      issue(1'b1, 19999, 6'b010101, 1'b0, a0); wait_idle();
      issue(1'b0, 19999, 6'b000000, 1'b0, a0); wait_idle();
      issue(1'b0, 20000, 6'b000000, 1'b0, a0); wait_idle();
      issue(1'b1, 32767, 6'b101010, 1'b0, a0); wait_idle();
      issue(1'b0, 5, 6'b000000, 1'b0, a0);   wait_idle();

      // Abort a read of 100 during STROBE: digit is lost, no response follows.
      issue(1'b0, 100, 6'b000000, 1'b0, a0);
      @(posedge clk); #1;
      reset = 1'b1;
      sbq.delete();
      model[100] = 6'b000000;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      issue(1'b0, 100, 6'b000000, 1'b0, a0); wait_idle();

      issue(1'b1, 200, 6'b100000, 1'b1, a0);
      issue(1'b1, 201, 6'b000111, 1'b1, a1);
      issue(1'b0, 200, 6'b000000, 1'b0, a2);
      chk("b2b_gap1", a1 - a0, 5);
      chk("b2b_gap2", a2 - a1, 5);
      wait_idle();
      issue(1'b0, 201, 6'b000000, 1'b0, a0); wait_idle();

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
